// File: rtl/ih_pkg.sv
// Shared types for the interrupt path: source encoding, dispatcher FSM states
// and the source-to-vector index helper.
package ih_pkg;

    typedef enum logic [1:0] {
        timer_is    = 2'd0,
        input_is    = 2'd1,
        gpio_is     = 2'd2,
        external_is = 2'd3
    } interrupt_source;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT    = 3'd1,
        VECTOR  = 3'd2,
        HANDLER = 3'd3,
        RETURN  = 3'd4
    } dispatch_state;

    localparam int NUM_SOURCES = 4;
    localparam int SVC_CNT_W   = 16;

    function automatic logic [1:0] source_index(interrupt_source src);
        return 2'(src);
    endfunction

endpackage

// File: rtl/interrupt_dispatcher_if.sv
// Requester <-> dispatcher handshake. The requester holds interrupt_requested
// (with a stable interrupt_source) until it sees interrupt_ack; interrupt_ack
// is a one-cycle grant, and interrupts_enabled tells the requester whether a
// new request can currently be taken.
interface interrupt_dispatcher_if;
    logic                    interrupt_requested;
    ih_pkg::interrupt_source interrupt_source;
    logic                    interrupts_enabled;
    logic                    interrupt_ack;

    modport master (
        output interrupt_requested,
        output interrupt_source,
        input  interrupts_enabled,
        input  interrupt_ack
    );

    modport slave (
        input  interrupt_requested,
        input  interrupt_source,
        output interrupts_enabled,
        output interrupt_ack
    );
endinterface

// File: rtl/interrupt_dispatcher_context_save.sv
// Holds the PC and status flags of the interrupted instruction stream until
// the handler returns.
module context_save #(
    parameter int ADDR_W = 32,
    parameter int FLAG_W = 8
) (
    input  logic              clk_i,
    input  logic              clear_i,
    input  logic              capture_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [FLAG_W-1:0] flags_i,
    output logic [ADDR_W-1:0] saved_pc_o,
    output logic [FLAG_W-1:0] saved_flags_o
);

    logic [ADDR_W-1:0] saved_pc_q;
    logic [FLAG_W-1:0] saved_flags_q;

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            saved_pc_q    <= '0;
            saved_flags_q <= '0;
        end else if (capture_i) begin
            saved_pc_q    <= pc_i;
            saved_flags_q <= flags_i;
        end
    end

    assign saved_pc_o    = saved_pc_q;
    assign saved_flags_o = saved_flags_q;

endmodule

// File: rtl/interrupt_dispatcher.sv
// CPU-side interrupt dispatcher: grants requests at instruction boundaries,
// vectors fetch per source and restores context on reti.
// Optional per-source service counters: define IRQ_SVC_COUNT_EN.
module interrupt_dispatcher
    import ih_pkg::*;
#(
    parameter int                ADDR_W        = 32,
    parameter int                FLAG_W        = 8,
    parameter logic [ADDR_W-1:0] VECTOR_BASE   = ADDR_W'(32'h0000_0100),
    parameter int                VECTOR_STRIDE = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    interrupt_dispatcher_if.slave   irq,
    input  logic                    ie_set,
    input  logic                    ie_clr,
    input  logic                    instr_boundary,
    input  logic [ADDR_W-1:0]       cur_pc,
    input  logic [FLAG_W-1:0]       cur_flags,
    input  logic                    reti,
    output logic                    redirect_valid,
    output logic [ADDR_W-1:0]       redirect_pc,
    output logic                    restore_flags_valid,
    output logic [FLAG_W-1:0]       restore_flags,
    output logic                    in_handler,
    output ih_pkg::interrupt_source active_source,
    output ih_pkg::dispatch_state   dbg_state
`ifdef IRQ_SVC_COUNT_EN
    ,
    input  logic                    svc_count_clr,
    output logic [NUM_SOURCES*SVC_CNT_W-1:0] svc_counts
`endif
);

    dispatch_state     state_q, state_d;
    interrupt_source   active_source_q, active_source_d;
    logic              ie_q, ie_d;
    logic              capture;
    logic              enabled;
    logic [ADDR_W-1:0] saved_pc;
    logic [FLAG_W-1:0] saved_flags;
    logic [ADDR_W-1:0] vector_pc;

    context_save #(
        .ADDR_W(ADDR_W),
        .FLAG_W(FLAG_W)
    ) u_ctx (
        .clk_i        (clk),
        .clear_i      (rst),
        .capture_i    (capture),
        .pc_i         (cur_pc),
        .flags_i      (cur_flags),
        .saved_pc_o   (saved_pc),
        .saved_flags_o(saved_flags)
    );

    // Clear beats set so software can always close the window.
    always_comb begin
        ie_d = ie_q;
        if (ie_clr)      ie_d = 1'b0;
        else if (ie_set) ie_d = 1'b1;
    end

    assign enabled = ie_q & ((state_q == IDLE) | (state_q == WAIT));

    always_comb begin
        state_d         = state_q;
        active_source_d = active_source_q;
        capture         = 1'b0;
        case (state_q)
            IDLE: begin
                if (irq.interrupt_requested && enabled) state_d = WAIT;
            end
            WAIT: begin
                if (!irq.interrupt_requested) begin
                    state_d = IDLE;
                end else if (instr_boundary) begin
                    capture         = 1'b1;
                    active_source_d = irq.interrupt_source;
                    state_d         = VECTOR;
                end
            end
            VECTOR:  state_d = HANDLER;
            HANDLER: if (reti) state_d = RETURN;
            RETURN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            ie_q            <= 1'b0;
            active_source_q <= timer_is;
        end else begin
            state_q         <= state_d;
            ie_q            <= ie_d;
            active_source_q <= active_source_d;
        end
    end

    // Vector arithmetic is done at ADDR_W so large bases wrap rather than widen.
    assign vector_pc = VECTOR_BASE
                     + ADDR_W'(source_index(active_source_q)) * ADDR_W'(VECTOR_STRIDE);

    always_comb begin
        redirect_valid      = 1'b0;
        redirect_pc         = '0;
        restore_flags_valid = 1'b0;
        restore_flags       = '0;
        case (state_q)
            VECTOR: begin
                redirect_valid = 1'b1;
                redirect_pc    = vector_pc;
            end
            RETURN: begin
                redirect_valid      = 1'b1;
                redirect_pc         = saved_pc;
                restore_flags_valid = 1'b1;
                restore_flags       = saved_flags;
            end
            default: ;
        endcase
    end

    assign irq.interrupt_ack      = (state_q == VECTOR);
    assign irq.interrupts_enabled = enabled;
    assign in_handler    = (state_q == VECTOR) | (state_q == HANDLER) | (state_q == RETURN);
    assign active_source = active_source_q;
    assign dbg_state     = state_q;

`ifdef IRQ_SVC_COUNT_EN
    logic [SVC_CNT_W-1:0] cnt_q [NUM_SOURCES];

    // Counted in the VECTOR cycle, i.e. once per grant; clear has priority.
    always_ff @(posedge clk) begin
        if (rst || svc_count_clr) begin
            for (int i = 0; i < NUM_SOURCES; i++) cnt_q[i] <= '0;
        end else if (state_q == VECTOR) begin
            if (cnt_q[source_index(active_source_q)] != {SVC_CNT_W{1'b1}})
                cnt_q[source_index(active_source_q)] <= cnt_q[source_index(active_source_q)] + 1'b1;
        end
    end

    always_comb begin
        svc_counts = '0;
        for (int i = 0; i < NUM_SOURCES; i++)
            svc_counts[i*SVC_CNT_W +: SVC_CNT_W] = cnt_q[i];
    end
`endif

endmodule
